// File: rtl/sub_bytes_unit.sv
// ---------------------------------------------------------------------------
// sub_bytes_unit
//
// Purpose:
//   AES SubBytes engine. It accepts one 128-bit AES state and substitutes
//   every byte through the S-box, LANES bytes per cycle. Each lane has a
//   registered table lookup. The registered results are merged into a
//   result register one edge later. The finished block is then held until
//   the consumer takes it.
//
// Optional feature:
//   SBOX_INV_EN - when defined, inverse S-box tables are built and the inv
//                 input selects inverse substitution for the block. When it
//                 is undefined, inv is ignored and the forward S-box is used.
//
// Parameters:
//   LANES     - byte lookups per cycle (1, 2, 4, 8 or 16)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - synchronous active-high reset
//   in_valid  - a 128-bit block is offered on in_data
//   in_ready  - the unit can accept a block this cycle
//   in_data   - AES state, byte k = in_data[127-8k -: 8]
//   inv       - 0 = forward S-box, 1 = inverse S-box (sampled on accept)
//   out_valid - out_data holds a completed result
//   out_ready - the consumer takes the result
//   out_data  - substituted state, same byte order as in_data
//   busy      - a block is being processed (RUN or DRAIN)
//
// Handshake:
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer holds its data stable while valid is high and ready is
//   low. Ready may depend on the other side's valid or ready, but valid
//   never depends on ready.
// ---------------------------------------------------------------------------
module sub_bytes_unit #(
   parameter int LANES = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         inv,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   // ------------------------------------------------------------------------
   // Parameter legality
   // ------------------------------------------------------------------------
   if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16)
   begin : g_bad_lanes
      $error("sub_bytes_unit: LANES must be 1, 2, 4, 8 or 16");
   end

   // ------------------------------------------------------------------------
   // S-box tables
   // The tables are built at elaboration from the field definition:
   // multiplicative inverse in GF(2^8) mod x^8+x^4+x^3+x+1, followed by the
   // affine map. Entry x sits at bits [8x+7:8x].
   // ------------------------------------------------------------------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // a^254 is the inverse for a != 0 and maps 0 to 0, as the S-box needs.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [2047:0] build_fwd();
      logic [2047:0] t;
      t = '0;
      for (int x = 0; x < 256; x++) begin
         t[8*x +: 8] = sbox_calc(8'(x));
      end
      return t;
   endfunction

   localparam logic [2047:0] FWD_TBL = build_fwd();

`ifdef SBOX_INV_EN
   // The inverse table is the forward table read backwards.
   function automatic logic [2047:0] build_inv(input logic [2047:0] f);
      logic [2047:0] t;
      t = '0;
      for (int x = 0; x < 256; x++) begin
         t[8*int'(f[8*x +: 8]) +: 8] = 8'(x);
      end
      return t;
   endfunction

   localparam logic [2047:0] INV_TBL = build_inv(FWD_TBL);
`endif

   // ------------------------------------------------------------------------
   // FSM encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [4:0] STEP     = 5'(LANES);
   localparam logic [4:0] LAST_IDX = 5'(16 - LANES);

   logic [1:0]             state;
   logic [4:0]             idx;        // next byte to issue, 0..16
   logic [15:0][7:0]       data_q;     // element 15-k holds byte k
   logic [15:0][7:0]       res_q;      // same layout as data_q
   logic [LANES-1:0][7:0]  lane_in;
   logic [LANES-1:0][7:0]  lut_nx;
   logic [LANES-1:0][7:0]  lut_q;      // registered lookup results
   logic [3:0]             wr_base;    // first byte index of lut_q group
   logic                   wr_en;      // lut_q holds a group to merge
   logic                   accept;

`ifdef SBOX_INV_EN
   logic                   mode_q;     // inverse mode latched at accept
`else
   logic                   unused_inv;
   assign unused_inv = inv;
`endif

   // ------------------------------------------------------------------------
   // Handshake and status
   // ------------------------------------------------------------------------
   assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == S_DONE);
   assign busy      = (state == S_RUN) || (state == S_DRAIN);
   assign out_data  = res_q;

   // ------------------------------------------------------------------------
   // Lane selection and table lookup
   // Byte k lives in element 15-k, which is ~k for a 4-bit index. In RUN,
   // idx never exceeds 16-LANES, so idx+j stays inside 0..15.
   // ------------------------------------------------------------------------
   always_comb begin
      lane_in = '0;
      lut_nx  = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_in[j] = data_q[~(idx[3:0] + 4'(j))];
`ifdef SBOX_INV_EN
         lut_nx[j]  = mode_q ? INV_TBL[{lane_in[j], 3'b000} +: 8]
                             : FWD_TBL[{lane_in[j], 3'b000} +: 8];
`else
         lut_nx[j]  = FWD_TBL[{lane_in[j], 3'b000} +: 8];
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Datapath and FSM
   // Each RUN edge registers one lookup group. The following edge merges
   // that group into res_q, so the last group issued in RUN is merged
   // during DRAIN.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         data_q  <= '0;
         res_q   <= '0;
         lut_q   <= '0;
         wr_base <= '0;
         wr_en   <= 1'b0;
`ifdef SBOX_INV_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         wr_en <= 1'b0;
         if (wr_en) begin
            for (int j = 0; j < LANES; j++) begin
               res_q[~(wr_base + 4'(j))] <= lut_q[j];
            end
         end

         case (state)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  data_q <= in_data;
                  idx    <= '0;
                  state  <= S_RUN;
`ifdef SBOX_INV_EN
                  mode_q <= inv;
`endif
               end else if (state == S_DONE && out_ready) begin
                  state <= S_IDLE;
               end
            end

            S_RUN: begin
               lut_q   <= lut_nx;
               wr_base <= idx[3:0];
               wr_en   <= 1'b1;
               idx     <= idx + STEP;
               if (idx == LAST_IDX) state <= S_DRAIN;
            end

            S_DRAIN: begin
               state <= S_DONE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sub_bytes_unit.md
SUB_BYTES_UNIT -- requirements
Module: sub_bytes_unit

Interface
REQ-001 SHALL have parameter LANES, default 4: byte lookups per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a 128-bit block is offered.
REQ-005 SHALL have port in_ready, output, 1 bit: the unit can accept a block.
REQ-006 SHALL have port in_data, input, 128 bits: AES state; byte k = in_data[127-8k -: 8], k = 0..15.
REQ-007 SHALL have port inv, input, 1 bit: 0 = forward S-box, 1 = inverse S-box; sampled on accept.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 SHALL have port out_data, output, 128 bits: substituted state, same byte order as in_data.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN or DRAIN.

Function
REQ-012 SHALL use an FSM with states IDLE, RUN, DRAIN and DONE.
REQ-013 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready).
REQ-014 SHALL accept a block on any edge where in_valid && in_ready: latch in_data and inv, clear the byte counter, go to RUN.
REQ-015 In RUN, SHALL present bytes idx..idx+LANES-1 to LANES registered lookup tables per cycle, add LANES to idx, and go to DRAIN after the 16/LANES-th issue.
REQ-016 Each lookup SHALL have exactly one cycle of latency; its registered result SHALL be written into the matching byte of the result register on the following edge.
REQ-017 DRAIN SHALL last one cycle to write the final lookup group, then go to DONE.
REQ-018 out_valid SHALL be high only in DONE; it rises exactly 16/LANES+1 edges after the accepting edge.
REQ-019 In DONE, out_data SHALL stay stable until out_valid && out_ready; the unit then goes to IDLE, or to RUN if a new block is accepted on the same edge (zero-bubble back-to-back).
REQ-020 in_valid SHALL be ignored while in RUN or DRAIN; inv SHALL be ignored except on the accepting edge.
REQ-021 Lookup tables SHALL implement FIPS-197 S-box and inverse S-box exactly across all 256 inputs.
REQ-022 The byte counter SHALL be 5 bits wide and SHALL never exceed 16.

Reset
REQ-023 With rst high on an edge, the FSM SHALL go to IDLE, and out_valid, busy, out_data, the counter and all lookup registers SHALL go to 0; in_ready is 1 in the following cycle.
REQ-024 Reset asserted in RUN, DRAIN or DONE SHALL abort the block and produce no output for it; rst has priority over every handshake.

Configuration
REQ-025 With macro SBOX_INV_EN defined, SHALL instantiate inverse tables and honour inv per REQ-007.
REQ-026 Without SBOX_INV_EN, SHALL omit inverse tables, keep the inv port but ignore it, and always apply the forward S-box.

Verification
REQ-027 LANES=4, forward: in_data all 0x00 -> out_valid exactly 5 edges after accept; out_data all 0x63.
REQ-028 LANES=1, forward: in_data 0x00112233445566778899aabbccddeeff -> after 17 edges, out_data 0x638293c31bfc33f5c4eeacea4bc12816.
REQ-029 SBOX_INV_EN, LANES=16, inv=1: in_data 0x638293c31bfc33f5c4eeacea4bc12816 -> after 2 edges, out_data 0x00112233445566778899aabbccddeeff.
REQ-030 out_ready held low for 10 cycles in DONE -> out_data and out_valid stable throughout; with in_valid high, the next block is accepted on the same edge out_ready rises; both results are correct.
REQ-031 rst pulsed in cycle 2 of RUN -> no out_valid for the aborted block; the next block completes with the correct result.
REQ-032 Exhaustive table check: all 256 byte values under forward mode, and under inverse mode when SBOX_INV_EN is defined -> match the FIPS-197 tables exactly.
